// File: rtl/register_arbiter.sv
// register_arbiter: round-robin arbiter that lets two requesters share one W-bit register,
// issuing one write strobe per granted request and counting the committed writes.
module register_arbiter #(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [1:0]   req_i,
    input  logic [W-1:0] din0_i,
    input  logic [W-1:0] din1_i,
    output logic [1:0]   gnt_o,
    output logic [1:0]   ack_o,
    output logic         reg_we_o,
    output logic [W-1:0] reg_d_o,
    output logic         busy_o,
    output logic [W-1:0] wr_count_o
);
    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic         prio_q, prio_d;
    logic [W-1:0] hold_q, hold_d;
    logic [W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_i != 2'b00) begin
                state_d = GRANT;
                // a tie goes to the priority pointer, otherwise the lone requester wins
                owner_d = (req_i == 2'b11) ? prio_q : req_i[1];
            end
            GRANT: begin
                state_d = COMMIT;
                hold_d  = owner_q ? din1_i : din0_i;
            end
            COMMIT: begin
                state_d = IDLE;
                prio_d  = ~owner_q;
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o      = (state_q == GRANT)  ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign ack_o      = (state_q == COMMIT) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign reg_we_o   = (state_q == COMMIT);
    assign busy_o     = (state_q != IDLE);
    assign reg_d_o    = hold_q;
    assign wr_count_o = cnt_q;
endmodule

// File: tb/tb_register_arbiter.sv
// tb_register_arbiter: directed stimulus with a transaction-level reference model,
// checking a W=7 and a W=3 instance every cycle plus literal expectations.
module tb_register_arbiter;
    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [1:0] req_i = 2'b11;
    logic [6:0] din0_i = 7'd1;
    logic [6:0] din1_i = 7'd7;

    logic [1:0] gnt7, ack7, gnt3, ack3;
    logic       we7, we3, busy7, busy3;
    logic [6:0] d7, cnt7;
    logic [2:0] d3, cnt3;

    int compared = 0;
    int mismatched = 0;
    bit en = 1'b0;
    int cyc = 0;
    int we_t[$];
    int ack_own[$];

    always #5 clk = ~clk;

    register_arbiter #(.W(7)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .din0_i(din0_i), .din1_i(din1_i),
        .gnt_o(gnt7), .ack_o(ack7), .reg_we_o(we7), .reg_d_o(d7), .busy_o(busy7), .wr_count_o(cnt7)
    );

    register_arbiter #(.W(3)) dut3 (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .din0_i(din0_i[2:0]), .din1_i(din1_i[2:0]),
        .gnt_o(gnt3), .ack_o(ack3), .reg_we_o(we3), .reg_d_o(d3), .busy_o(busy3), .wr_count_o(cnt3)
    );

    // Transaction model: m_left counts the cycles still owed to the current write
    int   m_left = 0;
    int   m_own = 0;
    int   m_prio = 0;
    int   m_hold = 0;
    int   m_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (!reset_i) begin
            m_left = 0; m_own = 0; m_prio = 0; m_hold = 0; m_cnt = 0;
        end else if (m_left == 2) begin
            m_hold = (m_own == 1) ? int'(din1_i) : int'(din0_i);
            m_left = 1;
        end else if (m_left == 1) begin
            m_cnt++;
            m_prio = 1 - m_own;
            m_left = 0;
        end else if (req_i != 2'b00) begin
            m_own  = (req_i == 2'b11) ? m_prio : int'(req_i == 2'b10);
            m_left = 2;
        end
    end

    task automatic chk(input string n, input longint a, input longint e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", n, a, e, cyc);
        end
    endtask

    always @(negedge clk) if (en) begin
        automatic longint og = (m_left == 2) ? (1 << m_own) : 0;
        automatic longint oa = (m_left == 1) ? (1 << m_own) : 0;
        chk("gnt", gnt7, og);
        chk("ack", ack7, oa);
        chk("reg_we", we7, m_left == 1);
        chk("busy", busy7, m_left != 0);
        chk("reg_d", d7, m_hold % 128);
        chk("wr_count", cnt7, m_cnt % 128);
        chk("gnt_w3", gnt3, og);
        chk("ack_w3", ack3, oa);
        chk("reg_d_w3", d3, m_hold % 8);
        chk("wr_count_w3", cnt3, m_cnt % 8);
        if (we7) begin
            we_t.push_back(cyc);
            ack_own.push_back(int'(ack7[1]));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        step(1);
        en = 1'b1;
        step(1);
        chk("rst_gnt", gnt7, 0);
        chk("rst_busy", busy7, 0);
        chk("rst_cnt", cnt7, 0);
        // single write from requester 0
        reset_i = 1'b1; req_i = 2'b01; din0_i = 7'd1;
        step(1);
        req_i = 2'b00;
        chk("sw_gnt", gnt7, 1);
        chk("sw_busy", busy7, 1);
        step(1);
        chk("sw_we", we7, 1);
        chk("sw_d", d7, 1);
        chk("sw_ack", ack7, 1);
        step(1);
        chk("sw_cnt", cnt7, 1);
        chk("sw_idle", busy7, 0);
        // tie after reset
        reset_i = 1'b0;
        step(1);
        reset_i = 1'b1; req_i = 2'b11; din0_i = 7'd1; din1_i = 7'd7;
        step(2);
        chk("tie1_ack", ack7, 1);
        chk("tie1_d", d7, 1);
        step(3);
        chk("tie2_ack", ack7, 2);
        chk("tie2_d", d7, 7);
        step(1);
        // sustained contention
        reset_i = 1'b0;
        step(1);
        reset_i = 1'b1;
        we_t.delete();
        ack_own.delete();
        step(18);
        req_i = 2'b00;
        chk("sus_cnt", cnt7, 6);
        chk("sus_n", ack_own.size(), 6);
        for (int i = 0; i < ack_own.size(); i++) chk("sus_own", ack_own[i], i % 2);
        for (int i = 1; i < we_t.size(); i++) chk("sus_gap", we_t[i] - we_t[i-1], 3);
        // abort during requester 1 grant
        din1_i = 7'd5; req_i = 2'b10;
        step(1);
        chk("ab_gnt", gnt7, 2);
        reset_i = 1'b0; req_i = 2'b00;
        step(1);
        reset_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ab_we", we7, 0);
            chk("ab_ack", ack7, 0);
            step(1);
        end
        chk("ab_cnt", cnt7, 0);
        req_i = 2'b11;
        step(1);
        chk("ab_tie", gnt7, 1);
        req_i = 2'b00;
        step(2);
        // wrap of the 3-bit counter
        reset_i = 1'b0;
        step(1);
        reset_i = 1'b1; req_i = 2'b01; din0_i = 7'd3;
        for (int k = 1; k <= 8; k++) begin
            step(3);
            if (k == 7) chk("wrap7", cnt3, 7);
            if (k == 8) chk("wrap0", cnt3, 0);
        end
        req_i = 2'b00;
        chk("wrap_w7", cnt7, 8);
        step(2);
        en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/register_arbiter.md
# register_arbiter

Round-robin arbiter that shares one W-bit storage register, such as the 7-bit `register` in `prac/counter`, between two requesters. Each requester presents a write request with data. The arbiter grants one requester, captures its data, and issues a single-cycle write strobe with the data to the register. It then acknowledges that requester. The block sits between the requesters and the register's `d` input and load control, and also keeps a wrapping count of committed writes.

## Interface
- `W`, default 7: data width, matching the shared register width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of `clk`).
- `req`  in  2  write request per requester; bit k belongs to requester k.
- `din0`  in  W  write data from requester 0.
- `din1`  in  W  write data from requester 1.
- `gnt`  out  2  one-hot grant; high for exactly the GRANT cycle.
- `ack`  out  2  one-hot acknowledge; high for exactly the COMMIT cycle.
- `reg_we`  out  1  write strobe to the shared register.
- `reg_d`  out  W  data to the shared register.
- `busy`  out  1  high in GRANT and COMMIT.
- `wr_count`  out  W  number of committed writes, modulo 2^W.

## Operation
- States:
  - IDLE: no transaction.
  - GRANT: owner selected; owner's data is sampled.
  - COMMIT: write issued.
- IDLE → GRANT: when `req` != 0, choose the owner.
  - One request high: that requester wins.
  - Both high: the requester indicated by priority pointer `prio` wins.
  - Latch the owner index.
  - `req` == 0: stay in IDLE.
- GRANT → COMMIT: unconditional.
  - `gnt[owner]`=1 during GRANT.
  - At the end of GRANT, capture the owner's `din` into hold register `hold`.
- COMMIT → IDLE: unconditional.
  - During COMMIT: `reg_we`=1, `reg_d`=`hold`, `ack[owner]`=1.
  - At the end of COMMIT: `prio` ← the non-owner index, `wr_count` ← `wr_count`+1.
- Outputs `gnt`, `ack`, `reg_we` and `busy` are decoded from registered state only; none depends combinationally on `req`.
- `reg_d` = `hold` in every state. It is meaningful only while `reg_we`=1.
- Once granted, a transaction always completes. Dropping `req` during GRANT or COMMIT does not abort it.
- `req` is ignored outside IDLE. No queueing: a request is sampled only on an IDLE cycle.
- Requester rules:
  - Hold `din` stable while its `gnt` is high.
  - Drop `req` in the cycle after its `ack` unless it wants another write. A `req` still high in the following IDLE cycle is treated as a new request.
- `wr_count` wraps: 2^W−1 → 0, with no flag.
- Reset values (`reset`=0 at an edge): state IDLE; `gnt`=0, `ack`=0, `reg_we`=0, `busy`=0; `hold`=0 (so `reg_d`=0); `wr_count`=0; `prio`=0 (requester 0 wins the first tie).
- Reset in GRANT or COMMIT: the transaction is discarded.
  - No `reg_we` or `ack` is issued after the reset edge.
  - `wr_count` and `prio` are not updated by the discarded transaction.

## Timing
- Request sampled in IDLE at edge N:
  - `gnt` high for cycle N..N+1.
  - `reg_we`/`ack` high for cycle N+1..N+2.
  - Back in IDLE from edge N+2.
- Latency: `req` seen → register write strobe = 2 cycles. The register holds the new value after edge N+2.
- Maximum throughput: one write per 3 cycles.
- Under continuous contention, grants strictly alternate.

## Test plan
- Reset: hold `reset`=0 for 2 edges with `req`=2'b11 → `gnt`=0, `ack`=0, `reg_we`=0, `busy`=0, `reg_d`=0, `wr_count`=0 throughout.
- Single write:
  - Stimulus: `req`=2'b01, `din0`=7'b0000001.
  - Next cycle: `gnt`=01, `busy`=1.
  - Following cycle: `reg_we`=1, `reg_d`=7'b0000001, `ack`=01.
  - Then IDLE with `wr_count`=1.
- Tie after reset:
  - Stimulus: `req`=2'b11, `din0`=7'b0000001, `din1`=7'b0000111.
  - First commit: `ack`=01, `reg_d`=0000001.
  - Second commit: `ack`=10, `reg_d`=0000111.
- Sustained contention: `req`=2'b11 held for 6 transactions → `ack` owners 0,1,0,1,0,1; `wr_count`=6; `reg_we` pulses spaced exactly 3 cycles apart.
- Abort by reset: assert `reset`=0 during a GRANT cycle of requester 1 → no `reg_we`/`ack` afterwards; `wr_count` unchanged; next tie grants requester 0.
- Wrap: with W=3, complete 8 writes → `wr_count` reads 7 after the 7th write and 0 after the 8th.
